// File: rtl/sa_drain.sv
// sa_drain: drains the bottom row of a skewed systolic array.
//
// Each column of the array produces its partial sums one cycle later than the
// column to its left. This block delays every column so that all columns of a
// row line up, checks that the aligned valid bits agree, optionally applies a
// ReLU, and queues the aligned row in a small FIFO for a ready/valid consumer.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   sync_reset  synchronous active-high clear (overrides push/pop)
//   act_en      1 = clamp negative column values to zero on write
//   col_in      COLS packed signed W-bit column results, column j at [j*W +: W]
//   col_valid   per-column valid, column j skewed j cycles after column 0
//   out_ready   consumer accepts out_data this cycle
//   out_data    FIFO head row (zero while the FIFO is empty)
//   out_valid   FIFO non-empty
//   count       FIFO occupancy, 0..DEPTH
//   overflow    sticky: an aligned row was dropped because the FIFO was full
//   skew_err    sticky: aligned valid bits were neither all 0 nor all 1
module sa_drain #(
    parameter int COLS  = 4,
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_reset,
    input  logic                     act_en,
    input  logic [COLS*W-1:0]        col_in,
    input  logic [COLS-1:0]          col_valid,
    input  logic                     out_ready,
    output logic [COLS*W-1:0]        out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     skew_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]    aligned_data [COLS];
    logic [COLS-1:0] aligned_vld;

    // Column j is delayed by COLS-1-j registers so that every column of a row
    // arrives together with the undelayed last column.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        if (j == COLS - 1) begin : g_direct
            assign aligned_data[j] = col_in[j*W +: W];
            assign aligned_vld[j]  = col_valid[j];
        end else begin : g_dly
            localparam int L = COLS - 1 - j;

            logic [W-1:0] data_q [L];
            logic [W-1:0] data_d [L];
            logic [L-1:0] vld_q;
            logic [L-1:0] vld_d;

            always_comb begin
                for (int k = 0; k < L; k++) begin
                    data_d[k] = '0;
                end
                vld_d = '0;
                if (!sync_reset) begin
                    data_d[0] = col_in[j*W +: W];
                    vld_d[0]  = col_valid[j];
                    for (int k = 1; k < L; k++) begin
                        data_d[k] = data_q[k-1];
                        vld_d[k]  = vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < L; k++) begin
                        data_q[k] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    for (int k = 0; k < L; k++) begin
                        data_q[k] <= data_d[k];
                    end
                    vld_q <= vld_d;
                end
            end

            assign aligned_data[j] = data_q[L-1];
            assign aligned_vld[j]  = vld_q[L-1];
        end
    end

    // Pointer increment that wraps at DEPTH regardless of pointer width.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [COLS*W-1:0] mem_q [DEPTH];
    logic [COLS*W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              skew_err_q, skew_err_d;

    logic [COLS*W-1:0] write_row;
    logic              row_all;
    logic              row_any;
    logic              full;
    logic              pop;
    logic              push;

    // ReLU on the aligned row: a set sign bit becomes zero, everything else
    // passes through at full width.
    always_comb begin
        write_row = '0;
        for (int j = 0; j < COLS; j++) begin
            if (act_en && aligned_data[j][W-1]) begin
                write_row[j*W +: W] = '0;
            end else begin
                write_row[j*W +: W] = aligned_data[j];
            end
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a row
    // when the consumer is draining it.
    always_comb begin
        row_all    = &aligned_vld;
        row_any    = |aligned_vld;
        full       = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) && out_ready;
        push       = row_all && (!full || pop);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        skew_err_d = skew_err_q;

        if (sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            skew_err_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = write_row;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (row_all && full && !pop) begin
                overflow_d = 1'b1;
            end
            if (row_any && !row_all) begin
                skew_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    // The head row is gated so stale entries never show while empty.
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_sa_drain.sv
// tb_sa_drain: directed testbench for sa_drain with a queue scoreboard.
// Rows are driven with the array skew; the expected (ReLU-applied) row is
// queued when its last column is driven and compared when it reaches the head
// of the DUT FIFO.
module tb_sa_drain;

    localparam int COLS  = 4;
    localparam int W     = 20;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [COLS*W-1:0] row_t;

    logic            clk;
    logic            rst;
    logic            sync_reset;
    logic            act_en;
    row_t            col_in;
    logic [COLS-1:0] col_valid;
    logic            out_ready;
    row_t            out_data;
    logic            out_valid;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            skew_err;

    sa_drain #(.COLS(COLS), .W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_reset (sync_reset),
        .act_en     (act_en),
        .col_in     (col_in),
        .col_valid  (col_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .count      (count),
        .overflow   (overflow),
        .skew_err   (skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert;
    int   n_fail;
    row_t sb[$];
    row_t feed_q[$];
    bit   ovf_exp;
    bit   skew_exp;

    // Compare one observation against its expected value.
    task automatic checkOutput(input string tag, input row_t obs, input row_t exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard state.
    task automatic check_state();
        row_t head;
        head = (sb.size() != 0) ? sb[0] : '0;
        checkOutput("out_valid", row_t'(out_valid), row_t'(sb.size() != 0));
        checkOutput("count", row_t'(count), row_t'(sb.size()));
        checkOutput("out_data", out_data, head);
        checkOutput("overflow", row_t'(overflow), row_t'(ovf_exp));
        checkOutput("skew_err", row_t'(skew_err), row_t'(skew_exp));
    endtask

    function automatic row_t relu(input row_t r, input bit act);
        row_t v;
        v = r;
        for (int j = 0; j < COLS; j++) begin
            if (act && v[j*W + W - 1]) v[j*W +: W] = '0;
        end
        return v;
    endfunction

    function automatic row_t mk_row(input int c0, input int c1, input int c2, input int c3);
        row_t r;
        r[0*W +: W] = c0[W-1:0];
        r[1*W +: W] = c1[W-1:0];
        r[2*W +: W] = c2[W-1:0];
        r[3*W +: W] = c3[W-1:0];
        return r;
    endfunction

    // Check outputs, update the scoreboard for the coming edge, advance.
    task automatic step(input bit complete, input row_t row_exp, input bit bad);
        check_state();
        if (sync_reset) begin
            sb.delete();
            ovf_exp  = 1'b0;
            skew_exp = 1'b0;
        end else begin
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (bad) begin
                skew_exp = 1'b1;
            end else if (complete) begin
                if (sb.size() < DEPTH) sb.push_back(row_exp);
                else ovf_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive feed_q[0..n-1] back-to-back with the array skew.
    // ready_mode: 0 = never ready, 1 = always ready, 2 = ready only when a row completes.
    task automatic applyStimulus(input int n, input bit act, input int drop_col,
                                 input int ready_mode, input int stop_after);
        for (int c = 0; c < n + COLS - 1 && c < stop_after; c++) begin
            int   r_done;
            bit   complete;
            row_t done_row;
            col_valid = '0;
            col_in    = '0;
            for (int j = 0; j < COLS; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < n && j != drop_col) begin
                    col_valid[j]     = 1'b1;
                    col_in[j*W +: W] = feed_q[r][j*W +: W];
                end
            end
            r_done   = c - (COLS - 1);
            complete = (r_done >= 0) && (r_done < n);
            done_row = '0;
            if (complete) done_row = relu(feed_q[r_done], act);
            act_en    = act;
            out_ready = (ready_mode == 1) || (ready_mode == 2 && complete);
            step(complete, done_row, complete && drop_col >= 0);
        end
        col_valid = '0;
        col_in    = '0;
        act_en    = 1'b0;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) begin
            col_valid = '0;
            col_in    = '0;
            out_ready = ready;
            step(1'b0, '0, 1'b0);
        end
    endtask

    task automatic sync_pulse();
        sync_reset = 1'b1;
        step(1'b0, '0, 1'b0);
        sync_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        ovf_exp    = 1'b0;
        skew_exp   = 1'b0;
        rst        = 1'b0;
        sync_reset = 1'b0;
        act_en     = 1'b0;
        col_in     = '0;
        col_valid  = '0;
        out_ready  = 1'b0;

        // Reset state
        #2;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3, 1'b1);

        // Single aligned row, consumer always ready
        $display("[TB] single row latency");
        feed_q = '{mk_row(100, 101, 102, 103)};
        applyStimulus(1, 1'b0, -1, 1, 99);
        idle(2, 1'b1);

        // ReLU on and off for the same row
        $display("[TB] relu");
        feed_q = '{mk_row(0, -1, 7, -5)};
        applyStimulus(1, 1'b1, -1, 1, 99);
        idle(2, 1'b1);
        applyStimulus(1, 1'b0, -1, 1, 99);
        idle(2, 1'b1);

        // Five rows into a four-deep FIFO with no consumer
        $display("[TB] overflow");
        feed_q = '{mk_row(1, 2, 3, 4), mk_row(5, 6, 7, 8), mk_row(9, 10, 11, 12),
                   mk_row(13, 14, 15, 16), mk_row(17, 18, 19, 20)};
        applyStimulus(5, 1'b0, -1, 0, 99);
        idle(1, 1'b0);
        idle(6, 1'b1);
        sync_pulse();

        // Full FIFO, push and pop on the same edge
        $display("[TB] full push+pop");
        feed_q = '{mk_row(21, 22, 23, 24), mk_row(25, 26, 27, 28),
                   mk_row(29, 30, 31, 32), mk_row(33, 34, 35, 36)};
        applyStimulus(4, 1'b0, -1, 0, 99);
        feed_q = '{mk_row(-37, 38, -39, 40)};
        applyStimulus(1, 1'b0, -1, 2, 99);
        idle(6, 1'b1);

        // Missing column 2 valid
        $display("[TB] skew error");
        sync_pulse();
        feed_q = '{mk_row(41, 42, 43, 44)};
        applyStimulus(1, 1'b0, -1, 0, 99);
        feed_q = '{mk_row(45, 46, 47, 48)};
        applyStimulus(1, 1'b0, 2, 0, 99);
        idle(2, 1'b0);
        sync_pulse();
        idle(2, 1'b0);

        // Asynchronous reset with rows in the FIFO and in the delay lines
        $display("[TB] mid-stream reset");
        feed_q = '{mk_row(51, 52, 53, 54), mk_row(55, 56, 57, 58)};
        applyStimulus(2, 1'b0, -1, 0, 99);
        feed_q = '{mk_row(61, 62, 63, 64), mk_row(65, 66, 67, 68)};
        applyStimulus(2, 1'b0, -1, 0, 3);
        rst = 1'b0;
        #1;
        sb.delete();
        ovf_exp  = 1'b0;
        skew_exp = 1'b0;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(COLS + 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_drain.md
SA_DRAIN -- requirements
Module: sa_drain

Interface
REQ-001 Parameter COLS, default 4, number of array columns drained (>=2).
REQ-002 Parameter W, default 20, width of one column partial sum.
REQ-003 Parameter DEPTH, default 4, output FIFO depth in aligned rows (power of two).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 sync_reset  input  1  synchronous clear, active-high.
REQ-007 act_en  input  1  1 = apply ReLU on write into FIFO.
REQ-008 col_in  input  COLS*W  bottom-row PE results; column j at bits [j*W +: W], signed.
REQ-009 col_valid  input  COLS  per-column valid; column j skewed j cycles later than column 0.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  COLS*W  FIFO head row, same column packing as col_in.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-014 overflow  output  1  sticky: aligned row dropped because FIFO full.
REQ-015 skew_err  output  1  sticky: aligned valid bits disagreed.

Function
REQ-016 Column j data and valid SHALL pass through a delay line of exactly COLS-1-j registers; column COLS-1 SHALL be undelayed.
REQ-017 Aligned row valid SHALL be the AND of all aligned valid bits; push occurs when it is 1.
REQ-018 If aligned valid bits are neither all 0 nor all 1, skew_err SHALL set on that edge; no push occurs.
REQ-019 When act_en=1 at push, each column value with sign bit set SHALL be written as 0; otherwise written unmodified (no width change, no saturation).
REQ-020 Latency: column COLS-1 sample present in cycle t with FIFO empty SHALL appear on out_data with out_valid=1 in cycle t+1.
REQ-021 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_data SHALL advance to next row or out_valid drops.
REQ-022 Push when count=DEPTH and no pop SHALL be dropped; overflow SHALL set; FIFO contents unchanged.
REQ-023 Simultaneous push and pop when full SHALL be accepted; count unchanged; no overflow.
REQ-024 Simultaneous push and pop when empty: pop is not possible (out_valid=0); push accepted, count becomes 1.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-026 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 overflow and skew_err SHALL remain set until rst or sync_reset.

Reset
REQ-028 rst low SHALL immediately clear delay lines, pointers, count, overflow, skew_err; out_valid=0, out_data=0.
REQ-029 sync_reset=1 SHALL perform the same clear at the next edge, overriding any push/pop that cycle.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight delayed samples; no row produced from pre-reset data.

Verification
REQ-031 COLS=4: column j valid in cycle 10+j with value 100+j, out_ready=1 -> cycle 14: out_valid=1, out_data={103,102,101,100}; cycle 15: out_valid=0.
REQ-032 act_en=1, skewed row {-5,7,-1,0} -> out_data {0,7,0,0}; act_en=0 same row -> {-5,7,-1,0}.
REQ-033 out_ready=0, push 5 skewed rows (DEPTH=4) -> count=4, overflow=1 after 5th; drain yields rows 1-4 in order, row 5 absent.
REQ-034 FIFO full, out_ready=1, new row arriving -> count stays 4, overflow stays 0, order preserved.
REQ-035 Column 2 valid missing from an otherwise skewed row -> skew_err=1, count unchanged; sync_reset pulse -> skew_err=0, count=0.
REQ-036 rst low for one cycle while 2 rows in delay lines and 2 in FIFO -> out_valid=0 immediately; no output afterwards without new input.
